bin2bcd_converter: RTL



---
 rtl/bin2bcd_converter_if.sv | 35 +++
 rtl/bin2bcd_converter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/bin2bcd_converter_if.sv
// rtl/bin2bcd_converter_if.sv - request/result bundle between a numeric source and bin2bcd_converter
//
// Purpose: groups the conversion request (start/value) and the registered
// conversion results so the converter exposes one port besides clock/reset.
// Signals:
//   start    request pulse, driven by master
//   value    signed 32-bit number to convert, driven by master
//   busy     conversion in progress, driven by slave
//   done     one-cycle pulse when results update, driven by slave
//   bcd      packed BCD digits, [3:0] = units, driven by slave
//   sign     value was negative, driven by slave
//   ovf      value not displayable, driven by slave
//   nz_mask  per-digit significance (leading-zero blanking), driven by slave
interface bin2bcd_converter_if #(
  parameter int DIGITS = 6
);
  logic                  start;
  logic [31:0]           value;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  sign;
  logic                  ovf;
  logic [DIGITS-1:0]     nz_mask;

  modport master (
    output start, value,
    input  busy, done, bcd, sign, ovf, nz_mask
  );

  modport slave (
    input  start, value,
    output busy, done, bcd, sign, ovf, nz_mask
  );
endinterface

// File: rtl/bin2bcd_converter.sv
// rtl/bin2bcd_converter.sv - iterative double-dabble signed binary to BCD converter
//
// Purpose: converts a signed 32-bit value into DIGITS packed BCD digits, one
// magnitude bit per clock, with sign, overflow and leading-zero mask outputs.
// Fixed latency: start accepted at edge N, done pulses at edge N+BIN_BITS+1.
// Ports:
//   fnd_clk  clock, all logic on rising edge
//   rst      synchronous active-high reset
//   bus      bin2bcd_converter_if.slave (start/value in, busy/done/bcd/sign/ovf/nz_mask out)
module bin2bcd_converter #(
  parameter int DIGITS   = 6,
  parameter int BIN_BITS = 20
) (
  input  logic                 fnd_clk,
  input  logic                 rst,
  bin2bcd_converter_if.slave   bus
);

  localparam int CNT_W = $clog2(BIN_BITS);
  localparam int ACC_W = 4 * DIGITS;

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) p = p * 32'd10;
    return p;
  endfunction

  // A negative number loses one digit position to the minus sign.
  localparam logic [31:0] MAX_POS = pow10(DIGITS) - 32'd1;
  localparam logic [31:0] MAX_NEG = pow10(DIGITS - 1) - 32'd1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_BITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state;
  logic [ACC_W-1:0]    acc;
  logic [BIN_BITS-1:0] sr;
  logic [CNT_W-1:0]    cnt;
  logic                sign_q;
  logic                ovf_q;

  logic [31:0]         mag;
  logic                ovf_next;
  logic [ACC_W-1:0]    acc_adj;
  logic [DIGITS-1:0]   nz_next;

  // 32-bit negate: -2^31 maps to 0x8000_0000, which the range check rejects.
  always_comb begin
    mag      = bus.value[31] ? (~bus.value + 32'd1) : bus.value;
    ovf_next = bus.value[31] ? (mag > MAX_NEG) : (mag > MAX_POS);
  end

  // Double-dabble correction: any digit >= 5 gets +3 so the following
  // left shift carries into the next decade.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // Digit i is significant if it or any higher digit is nonzero; units always shown.
  always_comb begin
    nz_next = '0;
    nz_next[DIGITS-1] = |acc[4*(DIGITS-1) +: 4];
    for (int i = DIGITS - 2; i >= 0; i--) begin
      nz_next[i] = nz_next[i+1] | (|acc[4*i +: 4]);
    end
    nz_next[0] = 1'b1;
  end

  always_ff @(posedge fnd_clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      sr          <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      ovf_q       <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.bcd     <= '0;
      bus.sign    <= 1'b0;
      bus.ovf     <= 1'b0;
      bus.nz_mask <= DIGITS'(1);
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sign_q <= bus.value[31];
            ovf_q  <= ovf_next;
            // Overflowed values still run the full loop on zero to keep latency fixed.
            sr     <= ovf_next ? '0 : mag[BIN_BITS-1:0];
            acc    <= '0;
            cnt    <= '0;
            state  <= CONV;
          end
        end
        CONV: begin
          bus.busy <= 1'b1;
          {acc, sr} <= {acc_adj[ACC_W-2:0], sr, 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) state <= DONE;
        end
        DONE: begin
          bus.busy    <= 1'b0;
          bus.done    <= 1'b1;
          bus.bcd     <= ovf_q ? '0 : acc;
          bus.sign    <= sign_q;
          bus.ovf     <= ovf_q;
          bus.nz_mask <= ovf_q ? DIGITS'(1) : nz_next;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
